serial_alu_sequencer: RTL

Multi-cycle ALU front end. It latches operands and an ALU control code, then evaluates one bit position per clock through an internal 1-bit ALU slice, carrying the carry bit in a register between cycles. The last bit position uses MSB slice logic (set, overflow). An SLT fix-up cycle then writes `set` into bit 0. It sits upstream of the datapath writeback and is the area-reduced alternative to the 32-slice ripple ALU, with an identical result and flag contract.

---
 rtl/serial_alu_sequencer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial ALU front end. Operands and the ALU control code are latched
// on an accepted start; one bit position is evaluated per clock through a 1-bit slice with the
// carry held in a register. The last position captures the MSB set/overflow terms, and a fix-up
// cycle publishes result, zero and overflow. Result/flag contract matches the ripple ALU.
//
// Optional build macro SERIAL_ALU_ABORT_EN adds an 'abort' input that cancels an operation in
// RUN or FIX without a done pulse and without touching result, zero or overflow.
module serial_alu_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SERIAL_ALU_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   localparam int unsigned IdxW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFix,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      OpAnd  = 2'b00,
      OpOr   = 2'b01,
      OpAdd  = 2'b10,
      OpLess = 2'b11
   } slice_op_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              a_inv_q, a_inv_d;
   logic              b_inv_q, b_inv_d;
   slice_op_e         op_q, op_d;
   logic              valid_q, valid_d;
   logic              arith_q, arith_d;
   logic              carry_q, carry_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]  shadow_q, shadow_d;
   logic              set_q, set_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              zero_q, zero_d;
   logic              overflow_q, overflow_d;

   logic              abort_req;
   logic              ctrl_valid;
   logic              ai, bi, sum, carry_next, slice_out;
   logic [WIDTH-1:0]  fix_value;

`ifdef SERIAL_ALU_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Recognise the six supported control codes; anything else yields a zero result.
   always_comb begin
      ctrl_valid = 1'b0;
      case (alu_ctrl)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: ctrl_valid = 1'b1;
         default: ctrl_valid = 1'b0;
      endcase
   end

   // 1-bit ALU slice evaluated at the current bit index.
   always_comb begin
      ai         = a_q[idx_q] ^ a_inv_q;
      bi         = b_q[idx_q] ^ b_inv_q;
      sum        = ai ^ bi ^ carry_q;
      carry_next = (ai & bi) | ((ai ^ bi) & carry_q);
      slice_out  = 1'b0;
      unique case (op_q)
         OpAnd:  slice_out = ai & bi;
         OpOr:   slice_out = ai | bi;
         OpAdd:  slice_out = sum;
         OpLess: slice_out = 1'b0;
         default: slice_out = 1'b0;
      endcase
   end

   // Value published in FIX: SLT takes the raw MSB of A-B, invalid codes force zero.
   always_comb begin
      fix_value = '0;
      if (valid_q) begin
         if (op_q == OpLess) begin
            fix_value = {{(WIDTH-1){1'b0}}, set_q};
         end else begin
            fix_value = shadow_q;
         end
      end
   end

   // Next-state logic of the sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start) state_d = StRun;
         end
         StRun: begin
            if (abort_req) begin
               state_d = StIdle;
            end else if (idx_q == LastIdx) begin
               state_d = StFix;
            end
         end
         StFix: begin
            state_d = abort_req ? StIdle : StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: operand latch, per-bit accumulation, and FIX publication.
   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      a_inv_d    = a_inv_q;
      b_inv_d    = b_inv_q;
      op_d       = op_q;
      valid_d    = valid_q;
      arith_d    = arith_q;
      carry_d    = carry_q;
      idx_d      = idx_q;
      shadow_d   = shadow_q;
      set_d      = set_q;
      ovf_pend_d = ovf_pend_q;
      result_d   = result_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               a_d      = src_a;
               b_d      = src_b;
               a_inv_d  = alu_ctrl[3];
               b_inv_d  = alu_ctrl[2];
               op_d     = slice_op_e'(alu_ctrl[1:0]);
               valid_d  = ctrl_valid;
               // Only 0010 and 0110 are valid codes with the ADD slice op.
               arith_d  = ctrl_valid && (alu_ctrl[1:0] == 2'b10);
               // Carry-in of 1 on b_invert forms the two's complement for SUB/SLT.
               carry_d  = alu_ctrl[2];
               idx_d    = '0;
               shadow_d = '0;
            end
         end
         StRun: begin
            carry_d         = carry_next;
            shadow_d[idx_q] = slice_out;
            if (idx_q == LastIdx) begin
               set_d      = sum;
               ovf_pend_d = arith_q & (carry_q ^ carry_next);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StFix: begin
            if (!abort_req) begin
               result_d   = fix_value;
               zero_d     = (fix_value == '0);
               overflow_d = valid_q & ovf_pend_q;
            end
         end
         default: ;
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         a_inv_q    <= 1'b0;
         b_inv_q    <= 1'b0;
         op_q       <= OpAnd;
         valid_q    <= 1'b0;
         arith_q    <= 1'b0;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         shadow_q   <= '0;
         set_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         a_inv_q    <= a_inv_d;
         b_inv_q    <= b_inv_d;
         op_q       <= op_d;
         valid_q    <= valid_d;
         arith_q    <= arith_d;
         carry_q    <= carry_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         set_q      <= set_d;
         ovf_pend_q <= ovf_pend_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy     = (state_q == StRun) || (state_q == StFix);
   assign done     = (state_q == StDone);
   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = overflow_q;

endmodule
